// File: rtl/axi_lite_apb_bridge.sv
// ============================================================================
// axi_lite_apb_bridge
//
// Purpose:
//   AXI4-Lite slave to APB3 master bridge. Each AXI read or write is turned
//   into exactly one APB transfer. Only one transaction is in flight at a
//   time. Reads and writes are arbitrated fairly by a round-robin pointer.
//   Address-decode errors, partial-strobe writes and APB timeouts are
//   reported through the AXI response channels.
//
// Parameters:
//   BASE_ADDR    AXI window base; bits [31:16] must match the request address,
//                bits [15:0] of the request are passed on to APB.
//   TIMEOUT_CYC  maximum number of ACCESS cycles spent waiting on iPready;
//                0 disables the timeout.
//
// Ports:
//   iClk, iRst                         clock (rising edge), sync active-high reset
//   iAwvalid/oAwready/iAwaddr          AXI write address channel
//   iWvalid/oWready/iWdata/iWstrb      AXI write data channel
//   oBvalid/iBready/oBresp             AXI write response channel
//   iArvalid/oArready/iAraddr          AXI read address channel
//   oRvalid/iRready/oRdata/oRresp      AXI read data channel
//   oPsel/oPenable/oPwrite/oPaddr/oPwdata   APB request
//   iPrdata/iPready/iPslverr           APB completion
// ============================================================================
module axi_lite_apb_bridge #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        iClk,
    input  logic        iRst,

    input  logic        iAwvalid,
    output logic        oAwready,
    input  logic [31:0] iAwaddr,

    input  logic        iWvalid,
    output logic        oWready,
    input  logic [31:0] iWdata,
    input  logic [3:0]  iWstrb,

    output logic        oBvalid,
    input  logic        iBready,
    output logic [1:0]  oBresp,

    input  logic        iArvalid,
    output logic        oArready,
    input  logic [31:0] iAraddr,

    output logic        oRvalid,
    input  logic        iRready,
    output logic [31:0] oRdata,
    output logic [1:0]  oRresp,

    output logic        oPsel,
    output logic        oPenable,
    output logic        oPwrite,
    output logic [15:0] oPaddr,
    output logic [31:0] oPwdata,

    input  logic [31:0] iPrdata,
    input  logic        iPready,
    input  logic        iPslverr
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        WRESP,
        RRESP,
        ERESP
    } BridgeState;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

    BridgeState  r_state;
    logic        r_ptrWrite;
    logic        r_isWrite;
    logic [15:0] r_tcnt;

    logic        r_psel;
    logic        r_penable;
    logic        r_pwrite;
    logic [15:0] r_paddr;
    logic [31:0] r_pwdata;
    logic        r_bvalid;
    logic [1:0]  r_bresp;
    logic        r_rvalid;
    logic [1:0]  r_rresp;
    logic [31:0] r_rdata;

    logic        w_wReq;
    logic        w_rReq;
    logic        w_grantW;
    logic        w_grantR;
    logic [31:0] w_addr;
    logic        w_decErr;
    logic        w_strbErr;
    logic        w_timeout;
    logic        w_apbFail;
    logic        w_respDone;

    // A write needs both AW and W together; a lone AW or W is left waiting.
    // When both directions ask at once, the round-robin pointer breaks the tie.
    assign w_wReq   = iAwvalid & iWvalid;
    assign w_rReq   = iArvalid;
    assign w_grantW = (r_state == IDLE) & w_wReq & (~w_rReq | r_ptrWrite);
    assign w_grantR = (r_state == IDLE) & w_rReq & (~w_wReq | ~r_ptrWrite);

    assign oAwready = w_grantW;
    assign oWready  = w_grantW;
    assign oArready = w_grantR;

    // Address of whichever request is being granted, and its error checks.
    // Decode errors take precedence over strobe errors.
    assign w_addr    = w_grantW ? iAwaddr : iAraddr;
    assign w_decErr  = (w_addr[31:16] != BASE_ADDR[31:16]);
    assign w_strbErr = w_grantW & (iWstrb != 4'hF);

    // The timeout fires on the last allowed ACCESS cycle if the slave is
    // still not ready; a ready slave on that same cycle still wins.
    assign w_timeout = (TIMEOUT_CYC != 0) & (r_tcnt == TIMEOUT_LAST);
    assign w_apbFail = ~iPready | iPslverr;

    // The error path answers on the channel matching the latched direction.
    assign w_respDone = r_isWrite ? iBready : iRready;

    assign oPsel    = r_psel;
    assign oPenable = r_penable;
    assign oPwrite  = r_pwrite;
    assign oPaddr   = r_paddr;
    assign oPwdata  = r_pwdata;
    assign oBvalid  = r_bvalid;
    assign oBresp   = r_bresp;
    assign oRvalid  = r_rvalid;
    assign oRresp   = r_rresp;
    assign oRdata   = r_rdata;

    // Bridge FSM. All APB and AXI response outputs are registered here and
    // returned to zero whenever the bridge goes back to IDLE, so IDLE always
    // presents an all-zero output picture. Reset drops any APB transfer and
    // any pending response immediately.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state    <= IDLE;
            r_ptrWrite <= 1'b1;
            r_isWrite  <= 1'b0;
            r_tcnt     <= '0;
            r_psel     <= 1'b0;
            r_penable  <= 1'b0;
            r_pwrite   <= 1'b0;
            r_paddr    <= '0;
            r_pwdata   <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= '0;
            r_rvalid   <= 1'b0;
            r_rresp    <= '0;
            r_rdata    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grantW || w_grantR) begin
                        // After any grant the other direction gets priority.
                        r_ptrWrite <= w_grantR;
                        r_isWrite  <= w_grantW;
                        if (w_decErr || w_strbErr) begin
                            r_state <= ERESP;
                            if (w_grantW) begin
                                r_bvalid <= 1'b1;
                                r_bresp  <= w_decErr ? RESP_DECERR : RESP_SLVERR;
                            end else begin
                                r_rvalid <= 1'b1;
                                r_rresp  <= RESP_DECERR;
                                r_rdata  <= '0;
                            end
                        end else begin
                            r_state   <= SETUP;
                            r_psel    <= 1'b1;
                            r_penable <= 1'b0;
                            r_pwrite  <= w_grantW;
                            r_paddr   <= {w_addr[15:2], 2'b00};
                            r_pwdata  <= w_grantW ? iWdata : 32'h0;
                            r_tcnt    <= '0;
                        end
                    end
                end

                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end

                ACCESS: begin
                    if (iPready || w_timeout) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_pwrite  <= 1'b0;
                        r_paddr   <= '0;
                        r_pwdata  <= '0;
                        if (r_isWrite) begin
                            r_state  <= WRESP;
                            r_bvalid <= 1'b1;
                            r_bresp  <= w_apbFail ? RESP_SLVERR : RESP_OKAY;
                        end else begin
                            r_state  <= RRESP;
                            r_rvalid <= 1'b1;
                            r_rresp  <= w_apbFail ? RESP_SLVERR : RESP_OKAY;
                            r_rdata  <= w_apbFail ? 32'h0 : iPrdata;
                        end
                    end else begin
                        r_tcnt <= r_tcnt + 16'd1;
                    end
                end

                WRESP: begin
                    if (iBready) begin
                        r_bvalid <= 1'b0;
                        r_bresp  <= '0;
                        r_state  <= IDLE;
                    end
                end

                RRESP: begin
                    if (iRready) begin
                        r_rvalid <= 1'b0;
                        r_rresp  <= '0;
                        r_rdata  <= '0;
                        r_state  <= IDLE;
                    end
                end

                ERESP: begin
                    if (w_respDone) begin
                        r_bvalid <= 1'b0;
                        r_bresp  <= '0;
                        r_rvalid <= 1'b0;
                        r_rresp  <= '0;
                        r_rdata  <= '0;
                        r_state  <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_apb_bridge.sv
// ============================================================================
// tb_axi_lite_apb_bridge
//
// Directed testbench for axi_lite_apb_bridge. Each transaction is planned as
// a timeline (accept cycle, number of ACCESS cycles, response window) from
// the bridge's latency rules; a compare process checks every DUT output on
// every falling edge against that timeline. A configurable APB slave model
// supplies wait states, stuck-low ready and slave errors.
// ============================================================================
module tb_axi_lite_apb_bridge;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          TMO  = 16;
    localparam int          NS   = 4;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iAwvalid;
    logic        oAwready;
    logic [31:0] iAwaddr;
    logic        iWvalid;
    logic        oWready;
    logic [31:0] iWdata;
    logic [3:0]  iWstrb;
    logic        oBvalid;
    logic        iBready;
    logic [1:0]  oBresp;
    logic        iArvalid;
    logic        oArready;
    logic [31:0] iAraddr;
    logic        oRvalid;
    logic        iRready;
    logic [31:0] oRdata;
    logic [1:0]  oRresp;
    logic        oPsel;
    logic        oPenable;
    logic        oPwrite;
    logic [15:0] oPaddr;
    logic [31:0] oPwdata;
    logic [31:0] iPrdata;
    logic        iPready;
    logic        iPslverr;

    axi_lite_apb_bridge #(
        .BASE_ADDR  (BASE),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .iClk    (iClk),
        .iRst    (iRst),
        .iAwvalid(iAwvalid),
        .oAwready(oAwready),
        .iAwaddr (iAwaddr),
        .iWvalid (iWvalid),
        .oWready (oWready),
        .iWdata  (iWdata),
        .iWstrb  (iWstrb),
        .oBvalid (oBvalid),
        .iBready (iBready),
        .oBresp  (oBresp),
        .iArvalid(iArvalid),
        .oArready(oArready),
        .iAraddr (iAraddr),
        .oRvalid (oRvalid),
        .iRready (iRready),
        .oRdata  (oRdata),
        .oRresp  (oRresp),
        .oPsel   (oPsel),
        .oPenable(oPenable),
        .oPwrite (oPwrite),
        .oPaddr  (oPaddr),
        .oPwdata (oPwdata),
        .iPrdata (iPrdata),
        .iPready (iPready),
        .iPslverr(iPslverr)
    );

    always #5 iClk = ~iClk;

    // Cycle index: value k during the period that follows the k-th rising edge.
    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    bit chkEn    = 1'b0;

    // APB slave model: ready after slvWait stalled ACCESS cycles, or never.
    int          slvWait  = 0;
    bit          slvStuck = 1'b0;
    bit          slvErr   = 1'b0;
    logic [31:0] slvRdata = 32'h0;
    int          accCnt;

    always @(posedge iClk) begin
        if (iRst || !(oPsel && oPenable) || iPready)
            accCnt <= 0;
        else
            accCnt <= accCnt + 1;
    end

    assign iPready  = oPsel && oPenable && !slvStuck && (accCnt >= slvWait);
    assign iPrdata  = slvRdata;
    assign iPslverr = slvErr;

    // Counts every cycle the DUT spends in ACCESS.
    int accessCnt = 0;
    always @(negedge iClk) if (oPsel === 1'b1 && oPenable === 1'b1) accessCnt <= accessCnt + 1;

    // Transaction plan slots.
    bit          sAct[NS];
    bit          sApb[NS];
    bit          sWr[NS];
    int          sA[NS];
    int          sAcc[NS];
    int          sHold[NS];
    logic [31:0] sPaddr[NS];
    logic [31:0] sPwdata[NS];
    logic [31:0] sRdata[NS];
    logic [1:0]  sResp[NS];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic waitCyc(input int n);
        while (cyc < n) tick();
    endtask

    // Plans one transaction from the bridge's rules: decode/strobe errors
    // answer immediately, otherwise SETUP + N ACCESS cycles then a response.
    task automatic planSlot(input int idx, input bit isWr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb,
                            input logic [31:0] prdata, input int waitc, input bit stuck,
                            input bit perr, input int hold, input int acceptCyc);
        bit dec;
        bit badStrb;
        dec     = (addr >> 16) != (BASE >> 16);
        badStrb = isWr && (strb != 4'hF);
        sApb[idx]    = !dec && !badStrb;
        sResp[idx]   = dec ? 2'b11 : badStrb ? 2'b10 : (stuck || perr) ? 2'b10 : 2'b00;
        sAcc[idx]    = stuck ? TMO : waitc + 1;
        sPaddr[idx]  = addr & 32'h0000_FFFC;
        sPwdata[idx] = isWr ? wdata : 32'h0;
        sRdata[idx]  = (!isWr && sResp[idx] == 2'b00) ? prdata : 32'h0;
        sWr[idx]     = isWr;
        sHold[idx]   = hold;
        sA[idx]      = acceptCyc;
        sAct[idx]    = 1'b1;
    endtask

    function automatic int respStart(input int idx);
        return sA[idx] + (sApb[idx] ? sAcc[idx] + 1 : 0);
    endfunction

    // Per-cycle comparison of every DUT output against the planned timelines.
    logic        eP, eE, eW, eBv, eRv, eAw, eAr;
    logic [31:0] ePa, ePw, eRd;
    logic [1:0]  eBr, eRr;

    always @(negedge iClk) begin
        if (chkEn) begin
            eP = 0; eE = 0; eW = 0; eBv = 0; eRv = 0; eAw = 0; eAr = 0;
            ePa = 0; ePw = 0; eRd = 0; eBr = 0; eRr = 0;
            for (int k = 0; k < NS; k++) begin
                if (sAct[k]) begin
                    if (sApb[k] && cyc >= sA[k] && cyc <= sA[k] + sAcc[k]) begin
                        eP  = 1;
                        eE  = (cyc >= sA[k] + 1);
                        eW  = sWr[k];
                        ePa = sPaddr[k];
                        ePw = sPwdata[k];
                    end
                    if (cyc >= respStart(k) && cyc <= respStart(k) + sHold[k]) begin
                        if (sWr[k]) begin
                            eBv = 1; eBr = sResp[k];
                        end else begin
                            eRv = 1; eRr = sResp[k]; eRd = sRdata[k];
                        end
                    end
                    if (cyc == sA[k] - 1) begin
                        if (sWr[k]) eAw = 1; else eAr = 1;
                    end
                end
            end
            checkOutput("psel",    32'(oPsel),    32'(eP));
            checkOutput("penable", 32'(oPenable), 32'(eE));
            checkOutput("pwrite",  32'(oPwrite),  32'(eW));
            checkOutput("paddr",   32'(oPaddr),   ePa);
            checkOutput("pwdata",  oPwdata,       ePw);
            checkOutput("bvalid",  32'(oBvalid),  32'(eBv));
            checkOutput("bresp",   32'(oBresp),   32'(eBr));
            checkOutput("rvalid",  32'(oRvalid),  32'(eRv));
            checkOutput("rresp",   32'(oRresp),   32'(eRr));
            checkOutput("rdata",   oRdata,        eRd);
            checkOutput("awready", 32'(oAwready), 32'(eAw));
            checkOutput("wready",  32'(oWready),  32'(eAw));
            checkOutput("arready", 32'(oArready), 32'(eAr));
        end
    end

    task automatic clearSlots();
        for (int k = 0; k < NS; k++) sAct[k] = 1'b0;
    endtask

    task automatic doReset();
        iRst     = 1'b1;
        iAwvalid = 0; iWvalid = 0; iArvalid = 0;
        iBready  = 0; iRready = 0;
        tick();
        clearSlots();
        chkEn = 1'b1;
        tick();
        iRst = 1'b0;
    endtask

    // Presents one request and plans it for acceptance on the next edge.
    task automatic applyStimulus(input bit isWr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] strb, input logic [31:0] prdata, input int waitc,
                                 input bit stuck, input bit perr, input int hold);
        slvWait = waitc; slvStuck = stuck; slvErr = perr; slvRdata = prdata;
        planSlot(0, isWr, addr, wdata, strb, prdata, waitc, stuck, perr, hold, cyc + 1);
        if (isWr) begin
            iAwaddr = addr; iWdata = wdata; iWstrb = strb;
            iAwvalid = 1; iWvalid = 1;
        end else begin
            iAraddr = addr; iArvalid = 1;
        end
        tick();
        iAwvalid = 0; iWvalid = 0; iArvalid = 0;
    endtask

    // Holds the response ready low for the planned hold cycles, then handshakes.
    task automatic finishTxn();
        waitCyc(respStart(0) + sHold[0]);
        iBready = 1; iRready = 1;
        tick();
        iBready = 0; iRready = 0;
        sAct[0] = 1'b0;
    endtask

    int a0;
    int accBefore;

    initial begin
        iRst = 1; iAwvalid = 0; iWvalid = 0; iArvalid = 0; iBready = 0; iRready = 0;
        iAwaddr = 0; iWdata = 0; iWstrb = 0; iAraddr = 0;
        clearSlots();
        doReset();

        // Reset state
        checkOutput("rst_psel",   32'(oPsel),   32'h0);
        checkOutput("rst_bvalid", 32'(oBvalid), 32'h0);
        checkOutput("rst_rvalid", 32'(oRvalid), 32'h0);
        checkOutput("rst_rdata",  oRdata,       32'h0);

        // Zero-wait write
        applyStimulus(1, 32'h0000_0010, 32'hA5A5_5A5A, 4'hF, 32'h0, 0, 0, 0, 0);
        a0 = sA[0];
        checkOutput("t1_psel_T1",    32'(oPsel),    32'h1);
        checkOutput("t1_penable_T1", 32'(oPenable), 32'h0);
        checkOutput("t1_paddr",      32'(oPaddr),   32'h0000_0010);
        checkOutput("t1_pwdata",     oPwdata,       32'hA5A5_5A5A);
        tick();
        checkOutput("t1_penable_T2", 32'(oPenable), 32'h1);
        tick();
        checkOutput("t1_bvalid_T3",  32'(oBvalid),  32'h1);
        checkOutput("t1_bresp",      32'(oBresp),   32'h0);
        finishTxn();

        // Read with three wait states and a five-cycle response stall
        applyStimulus(0, 32'h0000_0014, 32'h0, 4'h0, 32'h1234_5678, 3, 0, 0, 5);
        a0 = sA[0];
        waitCyc(a0 + 4);
        checkOutput("t2_rvalid_early", 32'(oRvalid), 32'h0);
        waitCyc(a0 + 5);
        checkOutput("t2_rvalid", 32'(oRvalid), 32'h1);
        checkOutput("t2_rdata",  oRdata,       32'h1234_5678);
        waitCyc(a0 + 10);
        checkOutput("t2_rvalid_held", 32'(oRvalid), 32'h1);
        checkOutput("t2_rdata_held",  oRdata,       32'h1234_5678);
        finishTxn();

        // Error responses: decode error write, partial strobe, decode error read
        applyStimulus(1, 32'h0001_0000, 32'h1111_1111, 4'hF, 32'h0, 0, 0, 0, 1);
        checkOutput("t4_decerr_bresp", 32'(oBresp), 32'h3);
        checkOutput("t4_decerr_psel",  32'(oPsel),  32'h0);
        finishTxn();
        applyStimulus(1, 32'h0000_0008, 32'h2222_2222, 4'h3, 32'h0, 0, 0, 0, 0);
        checkOutput("t4_strb_bresp", 32'(oBresp), 32'h2);
        finishTxn();
        applyStimulus(0, 32'h0002_0004, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 0, 0, 2);
        checkOutput("t4_decerr_rresp", 32'(oRresp), 32'h3);
        checkOutput("t4_decerr_rdata", oRdata,      32'h0);
        finishTxn();

        // Timeout on a read, then a slave error on a write
        accBefore = accessCnt;
        applyStimulus(0, 32'h0000_0030, 32'h0, 4'h0, 32'hCAFE_F00D, 0, 1, 0, 1);
        a0 = sA[0];
        waitCyc(a0 + 17);
        checkOutput("t5_access_cycles", 32'(accessCnt - accBefore), 32'd16);
        checkOutput("t5_psel_after",    32'(oPsel),  32'h0);
        checkOutput("t5_rresp",         32'(oRresp), 32'h2);
        checkOutput("t5_rdata",         oRdata,      32'h0);
        finishTxn();
        applyStimulus(1, 32'h0000_0020, 32'h0BAD_0BAD, 4'hF, 32'h0, 0, 0, 1, 1);
        tick(); tick();
        checkOutput("t5_slverr_bresp", 32'(oBresp), 32'h2);
        finishTxn();
        slvErr = 0;

        // Reset during ACCESS, then a normal write
        applyStimulus(1, 32'h0000_0040, 32'h5555_AAAA, 4'hF, 32'h0, 5, 0, 0, 0);
        tick();
        iRst = 1'b1;
        tick();
        clearSlots();
        checkOutput("t6_psel",    32'(oPsel),    32'h0);
        checkOutput("t6_penable", 32'(oPenable), 32'h0);
        checkOutput("t6_bvalid",  32'(oBvalid),  32'h0);
        iRst = 1'b0;
        applyStimulus(1, 32'h0000_0044, 32'h0F0F_F0F0, 4'hF, 32'h0, 0, 0, 0, 0);
        tick(); tick();
        checkOutput("t6_bvalid_after", 32'(oBvalid), 32'h1);
        checkOutput("t6_bresp_after",  32'(oBresp),  32'h0);
        finishTxn();

        // Simultaneous requests after reset: the write pointer starts at write,
        // so W1 goes first; the read and a second write then collide with the
        // pointer at read, so R1 precedes W2. Each zero-wait transfer with
        // ready held high occupies four cycles (SETUP, ACCESS, resp, IDLE).
        doReset();
        slvWait = 0; slvStuck = 0; slvErr = 0; slvRdata = 32'h7777_8888;
        iBready = 1; iRready = 1;
        a0 = cyc + 1;
        planSlot(0, 1, 32'h0000_0100, 32'hAAAA_0001, 4'hF, 32'h0, 0, 0, 0, 0, a0);
        planSlot(1, 0, 32'h0000_0104, 32'h0, 4'h0, 32'h7777_8888, 0, 0, 0, 0, a0 + 4);
        planSlot(2, 1, 32'h0000_0108, 32'hBBBB_0002, 4'hF, 32'h0, 0, 0, 0, 0, a0 + 8);
        iAwaddr = 32'h0000_0100; iWdata = 32'hAAAA_0001; iWstrb = 4'hF;
        iAwvalid = 1; iWvalid = 1;
        iAraddr = 32'h0000_0104; iArvalid = 1;
        tick();
        iAwaddr = 32'h0000_0108; iWdata = 32'hBBBB_0002;
        waitCyc(a0 + 4);
        checkOutput("t3_read_second", 32'(oPwrite), 32'h0);
        iArvalid = 0;
        waitCyc(a0 + 8);
        checkOutput("t3_write_third", 32'(oPwrite), 32'h1);
        iAwvalid = 0; iWvalid = 0;
        waitCyc(a0 + 12);
        iBready = 0; iRready = 0;
        clearSlots();
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_lite_apb_bridge.md
Name: axi_lite_apb_bridge

Overview:
AXI4-Lite slave to APB3 master bridge that sits directly upstream of the cipher subsystem's APB slave port. It converts CPU/interconnect register traffic into single APB transfers. It handles one transaction at a time, arbitrates fairly between reads and writes, and returns AXI responses including decode, strobe and timeout errors.

Parameters:
BASE_ADDR, 32'h0000_0000, AXI window base; bits [31:16] are compared, [15:0] pass through to APB.
TIMEOUT_CYC, 16, maximum ACCESS cycles waiting on iPready; 0 disables the timeout.

Ports:
iClk  in  1  clock, rising edge
iRst  in  1  synchronous reset, active-high
iAwvalid  in  1  / oAwready  out  1 / iAwaddr  in  32  write address channel
iWvalid  in  1  / oWready  out  1 / iWdata  in  32 / iWstrb  in  4  write data channel
oBvalid  out  1 / iBready  in  1 / oBresp  out  2  write response channel
iArvalid  in  1 / oArready  out  1 / iAraddr  in  32  read address channel
oRvalid  out  1 / iRready  in  1 / oRdata  out  32 / oRresp  out  2  read data channel
oPsel  out  1 / oPenable  out  1 / oPwrite  out  1 / oPaddr  out  16 / oPwdata  out  32  APB request
iPrdata  in  32 / iPready  in  1 / iPslverr  in  1  APB completion; tie iPslverr to 0 for slaves without it

Behaviour:
- Reset (iRst=1 at a rising edge):
  - Next cycle: state IDLE, all outputs 0, arbitration pointer = write, timeout counter 0.
  - Applies mid-transaction as well: the APB transfer is dropped immediately and any pending AXI response is discarded.
- States: IDLE, SETUP, ACCESS, WRESP, RRESP, ERESP. ERESP is the error-response path and produces no APB transfer.
- IDLE:
  - Write request = iAwvalid & iWvalid together; AW alone or W alone is not accepted.
  - Read request = iArvalid.
  - oAwready, oWready and oArready are combinational. They assert only in IDLE, only for the granted request.
  - If both requests are present, the pointer decides the grant; the pointer flips after every grant.
  - If only one request is present, it is granted and the pointer is set to the other type.
  - At the accept edge the bridge latches the address, data, strobe and direction.
- Address and strobe checks at accept:
  - addr[31:16] != BASE_ADDR[31:16]: goto ERESP with resp 2'b11 (DECERR).
  - Write with iWstrb != 4'hF: goto ERESP with 2'b10 (SLVERR).
  - Otherwise goto SETUP.
- APB timing:
  - SETUP: oPsel=1, oPenable=0.
  - ACCESS: oPsel=1, oPenable=1. oPaddr = {addr[15:2],2'b00}, stable from SETUP through ACCESS. oPwrite and oPwdata are stable for the whole transfer.
  - oPwdata = 0 for reads. All APB outputs are 0 outside SETUP and ACCESS.
- ACCESS completion:
  - iPready=1 completes the transfer. iPrdata is captured into oRdata (reads only).
  - resp = iPslverr ? 2'b10 : 2'b00.
  - Next state: WRESP or RRESP.
  - The timeout counter is cleared on SETUP entry.
- Timeout:
  - Each ACCESS cycle with iPready=0 increments the counter.
  - When counter == TIMEOUT_CYC-1 and iPready=0, the transfer is aborted: APB drops next cycle, resp = 2'b10, oRdata = 0.
- Latency with a zero-wait slave (iPready=1 in ACCESS): accept at edge T; SETUP in cycle T+1; ACCESS in T+2; oBvalid/oRvalid asserted in T+3.
- Response states:
  - WRESP/RRESP/ERESP hold valid, resp and data stable until iBready/iRready. ERESP drives oBvalid or oRvalid according to the latched direction.
  - The bridge returns to IDLE on the handshake edge. No new request is accepted in the same cycle as a response handshake.
  - Error reads return oRdata = 0.
- No outstanding transactions beyond one; no pipelining.

Test Plan:
1. BASE 0; write AW=0x0000_0010, W=0xA5A5_5A5A, strobe F; zero-wait slave -> PSEL@T+1, PENABLE@T+2, PADDR=0x0010, PWDATA=0xA5A5_5A5A, BVALID@T+3, BRESP=00.
2. Read AR=0x0000_0014 with PRDATA=0x1234_5678 and PREADY delayed 3 cycles -> RVALID 3 cycles later than zero-wait, RDATA=0x1234_5678, RRESP=00. Hold RREADY low 5 cycles -> RVALID and data held; all ready signals low.
3. Write and read both valid in the same cycle, twice in a row after reset -> first pair: write then read; second pair: read then write (pointer alternation).
4. Write AW=0x0001_0000 -> BRESP=11, no PSEL. Write with WSTRB=4'h3 -> BRESP=10, no PSEL. Read AR=0x0002_0004 -> RRESP=11, RDATA=0.
5. TIMEOUT_CYC=16, PREADY stuck at 0 -> exactly 16 ACCESS cycles, then PSEL=0, RRESP=10, RDATA=0. iPslverr=1 on completion -> RESP=10.
6. Assert iRst during ACCESS -> next cycle PSEL=PENABLE=BVALID=0, state IDLE. A new write afterwards completes normally with BRESP=00.
